// File: rtl/hough_peak_select.sv
// Per-frame Hough peak selector: tracks the strongest left/right-window cells of an
// accumulator scan and emits the winning angles as left-then-right one-cycle pulses.
module hough_peak_select #(
  parameter int unsigned THETA_W       = 8,
  parameter int unsigned RHO_W         = 11,
  parameter int unsigned VOTE_W        = 12,
  parameter int unsigned LEFT_MIN      = 10,
  parameter int unsigned LEFT_MAX      = 80,
  parameter int unsigned RIGHT_MIN     = 100,
  parameter int unsigned RIGHT_MAX     = 170,
  parameter int unsigned VOTE_MIN      = 32,
  parameter int unsigned LEFT_DEFAULT  = 45,
  parameter int unsigned RIGHT_DEFAULT = 135
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [THETA_W-1:0] in_theta,
  input  logic [RHO_W-1:0]   in_rho,
  input  logic [VOTE_W-1:0]  in_votes,
  input  logic               in_last,
  output logic [THETA_W-1:0] phase_left,
  output logic [THETA_W-1:0] phase_right,
  output logic [RHO_W-1:0]   rho_left,
  output logic [RHO_W-1:0]   rho_right,
  output logic               out_left_vld,
  output logic               out_right_vld,
  output logic               left_found,
  output logic               right_found,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT_L, EMIT_R} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_clear;
  logic w_accept;
  logic w_qual;
  logic w_win_l;
  logic w_win_r;
  logic w_cand_l;
  logic w_cand_r;
  logic w_upd_l;
  logic w_upd_r;

  logic [VOTE_W-1:0]  r_best_votes_l;
  logic [VOTE_W-1:0]  r_best_votes_r;
  logic [THETA_W-1:0] r_best_theta_l;
  logic [THETA_W-1:0] r_best_theta_r;
  logic [RHO_W-1:0]   r_best_rho_l;
  logic [RHO_W-1:0]   r_best_rho_r;
  logic               r_hit_l;
  logic               r_hit_r;

  logic               r_in_rdy;
  logic               r_busy;
  logic [THETA_W-1:0] r_phase_left;
  logic [THETA_W-1:0] r_phase_right;
  logic [RHO_W-1:0]   r_rho_left;
  logic [RHO_W-1:0]   r_rho_right;
  logic               r_out_left_vld;
  logic               r_out_right_vld;
  logic               r_left_found;
  logic               r_right_found;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; a frame_start inside SCAN restarts and swallows any same-cycle beat
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_state_nxt = SCAN;
          w_clear     = 1'b1;
        end
      end
      SCAN: begin
        if (frame_start) begin
          w_clear = 1'b1;
        end else if (in_vld) begin
          w_accept = 1'b1;
          if (in_last) begin
            w_state_nxt = EMIT_L;
          end
        end
      end
      EMIT_L:  w_state_nxt = EMIT_R;
      EMIT_R:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Candidate qualification of the accepted beat
  always_comb begin
    w_qual   = (in_votes >= VOTE_W'(VOTE_MIN));
    w_win_l  = (in_theta >= THETA_W'(LEFT_MIN))  && (in_theta <= THETA_W'(LEFT_MAX));
    w_win_r  = (in_theta >= THETA_W'(RIGHT_MIN)) && (in_theta <= THETA_W'(RIGHT_MAX));
    w_cand_l = w_accept && w_qual && w_win_l;
    w_cand_r = w_accept && w_qual && w_win_r;
    w_upd_l  = w_cand_l && (in_votes > r_best_votes_l);
    w_upd_r  = w_cand_r && (in_votes > r_best_votes_r);
  end

  // Running best per side; strict compare keeps the earliest of tied cells
  always_ff @(posedge clk) begin
    if (rst) begin
      r_best_votes_l <= '0;
      r_best_votes_r <= '0;
      r_best_theta_l <= '0;
      r_best_theta_r <= '0;
      r_best_rho_l   <= '0;
      r_best_rho_r   <= '0;
      r_hit_l        <= 1'b0;
      r_hit_r        <= 1'b0;
    end else if (w_clear) begin
      r_best_votes_l <= '0;
      r_best_votes_r <= '0;
      r_hit_l        <= 1'b0;
      r_hit_r        <= 1'b0;
    end else begin
      if (w_upd_l) begin
        r_best_votes_l <= in_votes;
        r_best_theta_l <= in_theta;
        r_best_rho_l   <= in_rho;
      end
      if (w_upd_r) begin
        r_best_votes_r <= in_votes;
        r_best_theta_r <= in_theta;
        r_best_rho_r   <= in_rho;
      end
      if (w_cand_l) begin
        r_hit_l <= 1'b1;
      end
      if (w_cand_r) begin
        r_hit_r <= 1'b1;
      end
    end
  end

  // Output registers; angles hold across frames without a hit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_rdy        <= 1'b0;
      r_busy          <= 1'b0;
      r_phase_left    <= THETA_W'(LEFT_DEFAULT);
      r_phase_right   <= THETA_W'(RIGHT_DEFAULT);
      r_rho_left      <= '0;
      r_rho_right     <= '0;
      r_out_left_vld  <= 1'b0;
      r_out_right_vld <= 1'b0;
      r_left_found    <= 1'b0;
      r_right_found   <= 1'b0;
    end else begin
      r_in_rdy        <= (w_state_nxt == SCAN);
      r_busy          <= (r_state != IDLE);
      r_out_left_vld  <= (r_state == EMIT_L);
      r_out_right_vld <= (r_state == EMIT_R);
      if (r_state == EMIT_L) begin
        r_left_found <= r_hit_l;
        if (r_hit_l) begin
          r_phase_left <= r_best_theta_l;
          r_rho_left   <= r_best_rho_l;
        end
      end
      if (r_state == EMIT_R) begin
        r_right_found <= r_hit_r;
        if (r_hit_r) begin
          r_phase_right <= r_best_theta_r;
          r_rho_right   <= r_best_rho_r;
        end
      end
    end
  end

  assign in_rdy        = r_in_rdy;
  assign busy          = r_busy;
  assign phase_left    = r_phase_left;
  assign phase_right   = r_phase_right;
  assign rho_left      = r_rho_left;
  assign rho_right     = r_rho_right;
  assign out_left_vld  = r_out_left_vld;
  assign out_right_vld = r_out_right_vld;
  assign left_found    = r_left_found;
  assign right_found   = r_right_found;

endmodule

// File: doc/hough_peak_select.md
# hough_peak_select

Per-frame Hough peak selector sitting directly upstream of the lane departure warning stage. It consumes the raster readout of the Hough accumulator as (theta, rho, votes) beats and tracks the strongest cell inside a left-lane theta window and a right-lane theta window. At frame end it emits the winning left and right angles as single-cycle valid pulses, left first and right one cycle later, matching the warning stage's right-valid-triggered pipeline.

## Interface
- THETA_W, 8: theta width in degrees (0..179).
- RHO_W, 11: rho width, two's complement.
- VOTE_W, 12: accumulator vote width, unsigned.
- LEFT_MIN / LEFT_MAX, 10 / 80: inclusive left-lane theta window.
- RIGHT_MIN / RIGHT_MAX, 100 / 170: inclusive right-lane theta window.
- VOTE_MIN, 32: minimum votes for a cell to qualify.
- LEFT_DEFAULT / RIGHT_DEFAULT, 45 / 135: held angles after reset (symmetric, offset rate = 1).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; opens a new accumulator scan.
- in_vld  in  1  accumulator beat valid.
- in_rdy  out  1  beat accepted when in_vld & in_rdy; high only in SCAN.
- in_theta  in  THETA_W  cell theta.
- in_rho  in  RHO_W  cell rho.
- in_votes  in  VOTE_W  cell vote count.
- in_last  in  1  qualifies the final beat of the scan.
- phase_left / phase_right  out  THETA_W  selected angles (registered, held between frames).
- rho_left / rho_right  out  RHO_W  rho of selected cells.
- out_left_vld / out_right_vld  out  1  one-cycle update pulses.
- left_found / right_found  out  1  1 = this frame's value is a fresh peak; 0 = held from an earlier frame.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states IDLE, SCAN, EMIT_L, EMIT_R.
  - IDLE -> SCAN on frame_start. The transition clears best_votes_l/r to 0 and hit_l/r to 0.
  - SCAN -> EMIT_L on an accepted beat with in_last=1.
  - SCAN + frame_start: restart. Bests are cleared. A beat presented in the same cycle is discarded, including one with in_last set.
  - EMIT_L -> EMIT_R -> IDLE, unconditionally, one cycle each. frame_start in EMIT_L/EMIT_R is ignored.
- Qualification of an accepted beat:
  - in_votes >= VOTE_MIN is required.
  - LEFT_MIN <= in_theta <= LEFT_MAX marks a left candidate.
  - RIGHT_MIN <= in_theta <= RIGHT_MAX marks a right candidate.
  - Any other theta is ignored.
- Update rule: a candidate replaces the side's best only if in_votes > best_votes (strict). Ties keep the earlier cell. Any qualified candidate sets hit for its side.
- Comparisons are unsigned on VOTE_W and THETA_W. No wrap or saturation is needed.
- EMIT_L:
  - If hit_l: phase_left <= best theta and rho_left <= best rho.
  - Otherwise phase_left and rho_left keep their values.
  - left_found <= hit_l and out_left_vld <= 1.
- EMIT_R: same for the right side one cycle later.
- Held values never equal 90 (windows exclude 90), so the downstream divisor (90 - phase_left) is never zero.
- in_vld while in_rdy=0 is dropped without effect. in_last without in_vld is ignored.

## Timing
- Reset values:
  - State IDLE; in_rdy=0, busy=0.
  - phase_left=LEFT_DEFAULT, phase_right=RIGHT_DEFAULT, rho_left=rho_right=0.
  - out_left_vld=out_right_vld=0, left_found=right_found=0.
- in_rdy goes high the cycle after frame_start is sampled in IDLE.
- Throughput: one beat per clock in SCAN.
- Let the last beat be accepted at edge k:
  - EMIT_L occupies cycle k..k+1.
  - out_left_vld is high for exactly one cycle after edge k+1.
  - out_right_vld is high for exactly one cycle after edge k+2. The two pulses never overlap.
  - busy falls after edge k+3.
- Minimum frame_start spacing after the last beat: 3 cycles. Earlier pulses are lost.
- rst mid-scan or mid-emit: all state returns to reset values on that edge, with no partial output pulse. Held angles revert to the defaults.

## Test plan
- Reset then idle: out_*_vld stay 0; phase_left=45, phase_right=135, in_rdy=0.
- Single frame, beats (60,100,50), (70,120,80), (120,-40,90), last (130,-50,70) -> out_left_vld at k+2 with phase_left=70, rho_left=120, left_found=1; out_right_vld at k+3 with phase_right=120, rho_right=-40.
- Ties and threshold: (40,*,64), (50,*,64), (30,*,31), (90,*,500) -> phase_left=40. Right side has no hit: right_found=0, phase_right holds its previous value.
- Restart: frame_start mid-SCAN after a 200-vote left beat at theta 20, then a new scan with only (75,*,40) -> phase_left=75.
- Backpressure/ignore: in_vld in IDLE and EMIT states and frame_start during EMIT_L -> no state change, no extra pulses.
- Reset asserted one cycle before out_left_vld -> no pulses; outputs return to the defaults.
